fifo_burst_reader: RTL and testbench

Read-side controller that drains a first-word-fall-through memory FIFO in host-commanded bursts and presents the words on a registered valid/ready output stream. It sits between the FIFO's read port (`fifo_rd_en`, `fifo_dout`, `fifo_empty`) and a downstream consumer. It frames each burst with a last-beat marker and signals completion with a one-cycle done pulse.

---
 rtl/fifo_burst_reader.sv | 130 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains a first-word-fall-through FIFO in bursts requested by a host and
//   presents the words on a registered valid/ready stream. The final beat of
//   each burst carries m_last, and a one-cycle done pulse marks completion.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start,burst_len : burst request and word count, sampled only in IDLE
//   busy, done      : burst in progress / one-cycle completion pulse
//   fifo_empty      : FIFO empty flag
//   fifo_dout       : FIFO head word (valid while fifo_empty is low)
//   fifo_rd_en      : pop request, FIFO advances on the edge where it is high
//   m_data, m_valid : registered output beat
//   m_last          : final beat of the burst
//   m_ready         : consumer accepts on an edge with m_valid && m_ready
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic pop;
  logic accept;

  // A pop is allowed only when the output register is free or is being
  // drained this very cycle, so a held beat is never overwritten.
  assign accept = m_valid_q && m_ready;
  assign pop    = (state_q == S_READ) && (rem_q != '0) && !fifo_empty &&
                  (!m_valid_q || m_ready);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    rem_d     = rem_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    // Output register: load on pop, clear on accept, otherwise hold.
    if (pop) begin
      m_data_d  = fifo_dout;
      m_valid_d = 1'b1;
      m_last_d  = (rem_q == LEN_WIDTH'(1));
      rem_d     = rem_q - LEN_WIDTH'(1);
    end else if (accept) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            rem_d   = burst_len;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      // The final pop always registers the last beat first, so FLUSH is
      // entered even if the consumer is ready on that same edge.
      S_READ:  if (pop && rem_q == LEN_WIDTH'(1)) state_d = S_FLUSH;
      S_FLUSH: if (accept && m_last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == S_READ) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader with a small FWFT FIFO model.
//   Cycle index k=0 is the cycle right after the start edge.
module tb_fifo_burst_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] burst_len;
  logic       busy;
  logic       done;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  int checks = 0;
  int errors = 0;

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FWFT FIFO model
  logic [7:0] mem [0:63];
  logic [6:0] wp = 7'd0;
  logic [6:0] rp = 7'd0;
  assign fifo_empty = (wp == rp);
  assign fifo_dout  = mem[rp[5:0]];
  always @(posedge clk) if (fifo_rd_en) rp <= rp + 7'd1;

  task automatic push(input logic [7:0] d);
    mem[wp[5:0]] = d;
    wp = wp + 7'd1;
  endtask

  // capture results
  logic [7:0] cap_data [$];
  logic       cap_last [$];
  int         cap_k    [$];
  bit         done_seen;
  int         done_cycle;
  logic       busy_at0;
  logic       busy_at_done;
  int         hold_viol;
  int         stall_pop;
  int         empty_pop;
  int         rd_count;
  int         refill_left;
  logic [7:0] next_val;

  task automatic clear_capture();
    cap_data.delete();
    cap_last.delete();
    cap_k.delete();
    done_seen    = 0;
    done_cycle   = -1;
    busy_at0     = 1'bx;
    busy_at_done = 1'bx;
    hold_viol    = 0;
    stall_pop    = 0;
    empty_pop    = 0;
    rd_count     = 0;
  endtask

  task automatic do_start(input logic [4:0] len);
    start     = 1'b1;
    burst_len = len;
    @(negedge clk);
    start     = 1'b0;
    burst_len = 5'd0;
  endtask

  // Records beats and protocol observations; performs no comparisons.
  // ready_mode 0: m_ready always 1; 1: pattern 1,0,0,...
  task automatic capture(input int max_cycles, input int ready_mode,
                         input int start_k, input int stop_beats);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (refill_left > 0) begin
        push(next_val);
        next_val    = next_val + 8'd1;
        refill_left = refill_left - 1;
      end
      m_ready   = (ready_mode == 0) ? 1'b1 : ((k % 3) == 0);
      start     = (k == start_k);
      burst_len = (k == start_k) ? 5'd2 : 5'd0;
      #1;
      if (k == 0) busy_at0 = busy;
      if (fifo_rd_en) rd_count++;
      if (fifo_rd_en && fifo_empty) empty_pop++;
      if (m_valid && !m_ready && fifo_rd_en) stall_pop++;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        hold_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data);
        cap_last.push_back(m_last);
        cap_k.push_back(k);
      end
      if (done && !done_seen) begin
        done_seen    = 1;
        done_cycle   = k;
        busy_at_done = busy;
      end
      @(negedge clk);
      if (done_seen) break;
      if (stop_beats > 0 && cap_data.size() >= stop_beats) break;
    end
    start     = 1'b0;
    burst_len = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; burst_len = 5'd0; m_ready = 1'b0;
    refill_left = 0; next_val = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, fifo_rd_en, m_valid, m_last, m_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b v=%b l=%b d=%h expected all 0",
               busy, done, fifo_rd_en, m_valid, m_last, m_data);
    end
    rst = 1'b0;
    push(8'hF0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_pop got busy=%b rd=%b expected 0 0", busy, fifo_rd_en);
    end
    // drain the probe word with a one-word burst
    clear_capture();
    do_start(5'd1);
    capture(20, 0, -1, 0);
    checks++;
    if (cap_data.size() != 1 || cap_data[0] !== 8'hF0 || cap_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_beat got n=%0d expected 1 beat F0 last", cap_data.size());
    end
    checks++;
    if (done_cycle != 2) begin
      errors++;
      $display("FAIL single_latency got done at k=%0d expected 2", done_cycle);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_d[i]) push(exp_d[i]);
    clear_capture();
    do_start(5'd4);
    capture(30, 0, -1, 0);
    checks++;
    if (busy_at0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_after_start got %b expected 1", busy_at0);
    end
    checks++;
    if (cap_data.size() != 4) begin
      errors++;
      $display("FAIL basic_count got %0d expected 4", cap_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == 3) || cap_k[i] != i + 1) begin
          errors++;
          $display("FAIL basic_beat%0d got d=%h l=%b k=%0d expected d=%h l=%b k=%0d",
                   i, cap_data[i], cap_last[i], cap_k[i], exp_d[i], (i == 3), i + 1);
        end
      end
    end
    checks++;
    if (done_cycle != 5 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got k=%0d busy=%b expected k=5 busy=0", done_cycle, busy_at_done);
    end
    checks++;
    if (done !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_after got done=%b empty=%b expected 0 1", done, fifo_empty);
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_d[i]) push(exp_d[i]);
    clear_capture();
    do_start(5'd4);
    capture(60, 1, -1, 0);
    checks++;
    if (cap_data.size() != 4 || !done_seen) begin
      errors++;
      $display("FAIL bp_count got n=%0d done=%0d expected 4 1", cap_data.size(), done_seen);
    end else begin
      checks++;
      if (cap_data[0] !== 8'h11 || cap_data[1] !== 8'h22 ||
          cap_data[2] !== 8'h33 || cap_data[3] !== 8'h44 || cap_last[3] !== 1'b1) begin
        errors++;
        $display("FAIL bp_order got %h %h %h %h last=%b expected 11 22 33 44 last=1",
                 cap_data[0], cap_data[1], cap_data[2], cap_data[3], cap_last[3]);
      end
    end
    checks++;
    if (hold_viol != 0 || stall_pop != 0) begin
      errors++;
      $display("FAIL bp_hold got hold_viol=%0d stall_pop=%0d expected 0 0", hold_viol, stall_pop);
    end
  endtask

  task automatic test_underflow();
    push(8'hA1);
    push(8'hA2);
    clear_capture();
    do_start(5'd3);
    capture(10, 0, -1, 0);
    checks++;
    if (cap_data.size() != 2 || cap_data[0] !== 8'hA1 || cap_last[1] !== 1'b0 || done_seen) begin
      errors++;
      $display("FAIL uf_first got n=%0d done=%0d expected 2 beats no done", cap_data.size(), done_seen);
    end
    checks++;
    if (busy !== 1'b1 || fifo_rd_en !== 1'b0 || empty_pop != 0) begin
      errors++;
      $display("FAIL uf_stall got busy=%b rd=%b empty_pop=%0d expected 1 0 0",
               busy, fifo_rd_en, empty_pop);
    end
    push(8'h55);
    clear_capture();
    capture(10, 0, -1, 0);
    checks++;
    if (cap_data.size() != 1 || cap_data[0] !== 8'h55 || cap_last[0] !== 1'b1 || !done_seen) begin
      errors++;
      $display("FAIL uf_resume got n=%0d done=%0d expected beat 55 last then done",
               cap_data.size(), done_seen);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    clear_capture();
    do_start(5'd0);
    capture(6, 0, -1, 0);
    checks++;
    if (done_cycle != 0 || busy_at0 !== 1'b0 || rd_count != 0 || cap_data.size() != 0) begin
      errors++;
      $display("FAIL zero_len got done_k=%0d busy=%b rd=%0d beats=%0d expected 0 0 0 0",
               done_cycle, busy_at0, rd_count, cap_data.size());
    end
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    clear_capture();
    do_start(5'd5);
    capture(30, 0, 2, 0);
    checks++;
    if (cap_data.size() != 5 || cap_data[4] !== 8'hB4 || cap_last[4] !== 1'b1 || cap_last[3] !== 1'b0) begin
      errors++;
      $display("FAIL ign_start got n=%0d expected 5 beats last on B4", cap_data.size());
    end
    checks++;
    if (done_cycle != 6) begin
      errors++;
      $display("FAIL ign_done got k=%0d expected 6", done_cycle);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL ign_idle got busy=%b empty=%b expected 0 1", busy, fifo_empty);
    end
  endtask

  task automatic test_max_len();
    for (int i = 1; i <= 8; i++) push(8'(i));
    next_val    = 8'd9;
    refill_left = 23;
    clear_capture();
    do_start(5'd31);
    capture(80, 0, -1, 0);
    checks++;
    if (cap_data.size() != 31) begin
      errors++;
      $display("FAIL max_count got %0d expected 31", cap_data.size());
    end else begin
      int bad;
      bad = 0;
      for (int i = 0; i < 31; i++)
        if (cap_data[i] !== 8'(i + 1) || cap_last[i] !== (i == 30)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL max_beats got %0d bad beats expected 0", bad);
      end
    end
    checks++;
    if (done_cycle != 32 || empty_pop != 0) begin
      errors++;
      $display("FAIL max_done got k=%0d empty_pop=%0d expected 32 0", done_cycle, empty_pop);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) push(8'h61 + 8'(i));
    clear_capture();
    do_start(5'd5);
    capture(20, 0, -1, 2);
    checks++;
    if (cap_data.size() != 2 || cap_data[1] !== 8'h62) begin
      errors++;
      $display("FAIL rst_pre got n=%0d expected 2 beats ending 62", cap_data.size());
    end
    rst     = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, fifo_rd_en, m_valid, m_last, m_data} !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b done=%b rd=%b v=%b l=%b d=%h expected all 0",
               busy, done, fifo_rd_en, m_valid, m_last, m_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got busy=%b rd=%b v=%b expected 0 0 0", busy, fifo_rd_en, m_valid);
    end
    clear_capture();
    do_start(5'd3);
    capture(20, 0, -1, 0);
    checks++;
    if (cap_data.size() != 3 || cap_data[0] !== 8'h64 || cap_data[1] !== 8'h65 ||
        cap_data[2] !== 8'h66 || cap_last[2] !== 1'b1 || done_cycle != 4) begin
      errors++;
      $display("FAIL rst_after got n=%0d done_k=%0d expected 64 65 66 done_k=4",
               cap_data.size(), done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_underflow();
    test_zero_and_ignored_start();
    test_max_len();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
